tx_status_encoder: RTL and testbench
====================================

TX_STATUS_ENCODER -- requirements
Module: tx_status_encoder

Interface
REQ-001 The block SHALL have ports i_clk (in, 1): the single clock; all logic is on its rising edge.
REQ-002 The block SHALL have port i_rst_n (in, 1): the reset, which is asynchronous and active-low.
REQ-003 The block SHALL have port Img_Select (in, 2): the current image source (0 = default, 1 = tp1, 2 = tp2, 3 = live).
REQ-004 The block SHALL have port Res_Select (in, 2): the current resolution code (0 = 640, 1 = 800, 2 = 1280, 3 = 1920).
REQ-005 The block SHALL have port Out_Select (in, 1): the current output port (0 = out1, 1 = out2).
REQ-006 The block SHALL have port status_req (in, 1): a one-cycle host request to resend the status frame.
REQ-007 The block SHALL have port tx_data (out, 8): the byte offered to the UART transmitter.
REQ-008 The block SHALL have port tx_valid (out, 1): tx_data holds a valid byte.
REQ-009 The block SHALL have port tx_ready (in, 1): the UART transmitter can accept a byte this cycle.
REQ-010 The block SHALL have port busy (out, 1): a frame is in progress.

Function
REQ-011 A frame SHALL be 4 bytes, in this order: '#' (0x23), code letter, CR (0x0D), LF (0x0A).
REQ-012 The code letter SHALL be computed as follows.
- Img_Select = 0: letter = 'y' (0x79).
- Otherwise: letter = 0x61 + (Img_Select-1)*8 + Out_Select*4 + Res_Select, in 8-bit unsigned arithmetic.
REQ-013 The FSM SHALL have two states, IDLE and SEND, plus a byte index idx of 2 bits (0..3).
REQ-014 In IDLE, a start SHALL occur when the pending flag is set or {Img_Select, Res_Select, Out_Select} differs from the last_sent register.
REQ-015 On the start edge the block SHALL do all of the following.
- Capture the inputs into snap and into last_sent.
- Clear the pending flag.
- Set idx = 0, tx_data = '#', tx_valid = 1, busy = 1.
- Enter SEND.
- tx_valid and the first byte are visible the cycle after the trigger is seen.
REQ-016 A byte SHALL transfer only on an edge where tx_valid = 1 and tx_ready = 1; while tx_ready = 0, tx_data and tx_valid SHALL hold stable.
REQ-017 On a transfer with idx < 3, the block SHALL increment idx and present the next byte on the same edge, with no bubble cycle.
REQ-018 On the transfer with idx = 3, the block SHALL set tx_valid = 0 and busy = 0 and return to IDLE; IDLE SHALL last at least one cycle before the next frame.
REQ-019 The code letter SHALL be derived from snap; input changes during SEND SHALL NOT alter the frame in progress.
REQ-020 Input changes during SEND SHALL cause exactly one further frame after return to IDLE, carrying the values present at that time.
REQ-021 A status_req asserted in any state SHALL set the pending flag.
REQ-022 If status_req coincides with the start edge, the pending flag SHALL remain set, so that one extra frame follows.
REQ-023 Multiple status_req pulses during one frame SHALL produce only one extra frame.
REQ-024 The block SHALL NOT drop, duplicate or reorder bytes, regardless of how long tx_ready stays low.

Reset
REQ-025 While i_rst_n = 0, the block SHALL hold tx_valid = 0, tx_data = 0x00, busy = 0, state = IDLE, idx = 0, pending = 0, and snap = last_sent = 0.
REQ-026 Assertion of reset mid-frame SHALL abort the frame and drop tx_valid immediately; no partial frame is resumed.
REQ-027 After reset release with all select inputs at 0, no frame SHALL be sent until an input change or a status_req occurs.

Structure
REQ-028 A shared package tx_status_pkg SHALL hold the following.
- The state enum {IDLE, SEND}.
- FRAME_LEN = 4.
- The ASCII constants HDR = 0x23, CR = 0x0D, LF = 0x0A, RST_CODE = 0x79, BASE_CODE = 0x61.
- The code-letter function.
REQ-029 The block SHALL be flat with no sub-module; the byte multiplexer and the letter encoder are inline.

Verification
REQ-030 Reset release, then set Img = 1, Res = 0, Out = 0 with tx_ready held at 1 -> the bench sees bytes 0x23, 0x61, 0x0D, 0x0A on 4 consecutive edges, then busy = 0.
REQ-031 Set Img = 2, Res = 3, Out = 1 and toggle tx_ready 1/0 -> the bench sees 0x23, 0x70, 0x0D, 0x0A, with tx_data stable while tx_ready = 0.
REQ-032 Set Img = 3, Res = 2, Out = 1, then change to Img = 0 during byte 1 -> the bench sees frame 0x23, 0x77, 0x0D, 0x0A, then frame 0x23, 0x79, 0x0D, 0x0A.
REQ-033 Pulse status_req 3 times during one frame with the inputs steady -> the bench sees exactly one extra identical frame.
REQ-034 Assert reset while idx = 2 -> tx_valid = 0 immediately; after release with inputs at 0, the bench sees no frame.

Source files
------------

// File: rtl/tx_status_encoder_pkg.sv
// Shared definitions for the UART status-frame encoder: FSM states,
// frame constants and the code-letter encoder.
package tx_status_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam int FRAME_LEN = 4;

    localparam logic [7:0] HDR       = 8'h23;
    localparam logic [7:0] CR        = 8'h0D;
    localparam logic [7:0] LF        = 8'h0A;
    localparam logic [7:0] RST_CODE  = 8'h79;
    localparam logic [7:0] BASE_CODE = 8'h61;

    // Letter layout: eight letters per image source, four per output port,
    // one per resolution; the default image gets its own fixed letter.
    function automatic logic [7:0] code_letter(input logic [1:0] img,
                                               input logic [1:0] res,
                                               input logic       out);
        logic [1:0] imgOfs;
        logic [7:0] letter;
        imgOfs = img - 2'd1;
        if (img == 2'd0) begin
            letter = RST_CODE;
        end else begin
            letter = BASE_CODE
                   + {3'd0, imgOfs, 3'd0}
                   + {5'd0, out, 2'd0}
                   + {6'd0, res};
        end
        return letter;
    endfunction

endpackage

// File: rtl/tx_status_encoder_if.sv
// Byte stream from the status encoder to the UART transmitter,
// using a valid/ready handshake.
interface tx_status_encoder_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/tx_status_encoder.sv
// Status-frame encoder: whenever the image/resolution/output selection
// changes, or the host asks for it, sends "#<letter>\r\n" to the UART
// one byte at a time over a valid/ready handshake.
module tx_status_encoder
    import tx_status_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [1:0]                 Img_Select,
    input  logic [1:0]                 Res_Select,
    input  logic                       Out_Select,
    input  logic                       status_req,
    tx_status_encoder_if.master        tx,
    output logic                       busy
);

    localparam logic [1:0] LAST_IDX = 2'(FRAME_LEN - 1);

    state_t     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       pending_q, pending_d;
    logic [4:0] snap_q, snap_d;
    logic [4:0] lastSent_q, lastSent_d;

    logic [4:0] sel;
    logic       start;
    logic       xfer;
    logic [7:0] letter;

    assign sel   = {Img_Select, Res_Select, Out_Select};
    assign start = (state_q == IDLE) && (pending_q || (sel != lastSent_q));
    assign xfer  = (state_q == SEND) && tx.tx_ready;

    // State register and frame bookkeeping, cleared asynchronously so a
    // reset mid-frame drops the transfer at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            idx_q      <= 2'd0;
            pending_q  <= 1'b0;
            snap_q     <= 5'd0;
            lastSent_q <= 5'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            snap_q     <= snap_d;
            lastSent_q <= lastSent_d;
        end
    end

    // Next state: start a frame on a change or pending request, advance the
    // byte index on each accepted byte, return to IDLE after the LF.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pending_d  = pending_q;
        snap_d     = snap_q;
        lastSent_d = lastSent_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SEND;
                    idx_d      = 2'd0;
                    pending_d  = 1'b0;
                    snap_d     = sel;
                    lastSent_d = sel;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = 2'd0;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 2'd0;
            end
        endcase

        // A request in the same cycle as a start must survive the clear.
        if (status_req) begin
            pending_d = 1'b1;
        end
    end

    // Outputs: the byte is chosen from the frozen snapshot and the index,
    // so the frame in flight is immune to input changes.
    always_comb begin
        letter      = code_letter(snap_q[4:3], snap_q[2:1], snap_q[0]);
        tx.tx_valid = (state_q == SEND);
        busy        = (state_q == SEND);
        tx.tx_data  = 8'h00;
        if (state_q == SEND) begin
            case (idx_q)
                2'd0:    tx.tx_data = HDR;
                2'd1:    tx.tx_data = letter;
                2'd2:    tx.tx_data = CR;
                default: tx.tx_data = LF;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_status_encoder.sv
// Bench for the status-frame encoder: a scoreboard queue of expected bytes
// is filled when stimulus is applied and drained by a handshake monitor.
module tb_tx_status_encoder;

    typedef struct {
        logic [1:0] img;
        logic [1:0] res;
        logic       out;
        logic [7:0] letter;
        int         mode;
    } vec_t;

    logic       clk = 1'b0;
    logic       rstN;
    logic [1:0] img;
    logic [1:0] res;
    logic       outSel;
    logic       statusReq;
    logic       busy;

    int         testsRun    = 0;
    int         testsFailed = 0;
    int         rdyMode     = 0;
    int         validCount  = 0;
    logic [7:0] expQ[$];
    logic       prevStall   = 1'b0;
    logic [7:0] prevData    = 8'h00;
    vec_t       vecs[7];

    tx_status_encoder_if txIf();

    tx_status_encoder dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .Img_Select (img),
        .Res_Select (res),
        .Out_Select (outSel),
        .status_req (statusReq),
        .tx         (txIf),
        .busy       (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushFrame(input logic [7:0] letter);
        expQ.push_back(8'h23);
        expQ.push_back(letter);
        expQ.push_back(8'h0D);
        expQ.push_back(8'h0A);
    endtask

    task automatic applyStimulus(input logic [1:0] i, input logic [1:0] r,
                                 input logic o, input logic [7:0] letter,
                                 input int mode);
        @(posedge clk);
        #1;
        rdyMode = mode;
        img     = i;
        res     = r;
        outSel  = o;
        pushFrame(letter);
    endtask

    task automatic waitDrain(input string name);
        int n;
        n = 0;
        while ((expQ.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_done"}, 32'(n < 300), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic waitByte(input logic [7:0] b, input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!(txIf.tx_valid && txIf.tx_data == b) && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(n < 100), 32'd1);
    endtask

    // Handshake driver for tx_ready: held high, toggled, or random.
    initial begin
        txIf.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdyMode)
                0:       txIf.tx_ready = 1'b1;
                1:       txIf.tx_ready = ~txIf.tx_ready;
                default: txIf.tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: compares each accepted byte with the scoreboard and checks
    // that a stalled byte stays put until it is taken.
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            if (txIf.tx_valid) validCount++;
            if (prevStall) begin
                checkOutput("stall_valid", 32'(txIf.tx_valid), 32'd1);
                checkOutput("stall_data", 32'(txIf.tx_data), 32'(prevData));
            end
            if (txIf.tx_valid && txIf.tx_ready) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_byte: got 0x%0h, expected none", txIf.tx_data);
                end else begin
                    checkOutput("byte", 32'(txIf.tx_data), 32'(expQ.pop_front()));
                end
            end
            prevStall = txIf.tx_valid && !txIf.tx_ready;
            prevData  = txIf.tx_data;
        end else begin
            prevStall = 1'b0;
        end
    end

    initial begin
        vecs[0] = '{img: 2'd2, res: 2'd3, out: 1'b1, letter: 8'h70, mode: 1};
        vecs[1] = '{img: 2'd3, res: 2'd2, out: 1'b1, letter: 8'h77, mode: 0};
        vecs[2] = '{img: 2'd0, res: 2'd1, out: 1'b1, letter: 8'h79, mode: 2};
        vecs[3] = '{img: 2'd1, res: 2'd3, out: 1'b1, letter: 8'h68, mode: 0};
        vecs[4] = '{img: 2'd3, res: 2'd0, out: 1'b0, letter: 8'h71, mode: 2};
        vecs[5] = '{img: 2'd2, res: 2'd1, out: 1'b0, letter: 8'h6A, mode: 1};
        vecs[6] = '{img: 2'd1, res: 2'd0, out: 1'b1, letter: 8'h65, mode: 2};

        rstN      = 1'b0;
        img       = 2'd0;
        res       = 2'd0;
        outSel    = 1'b0;
        statusReq = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", 32'(txIf.tx_valid), 32'd0);
        checkOutput("rst_data", 32'(txIf.tx_data), 32'h00);
        checkOutput("rst_busy", 32'(busy), 32'd0);

        // Quiet after reset release with all selects at zero.
        @(posedge clk);
        #1;
        rstN = 1'b1;
        validCount = 0;
        repeat (10) @(negedge clk);
        checkOutput("idle_after_reset", 32'(validCount), 32'd0);

        // Back-to-back bytes with tx_ready held high.
        applyStimulus(2'd1, 2'd0, 1'b0, 8'h61, 0);
        waitByte(8'h23, "first_frame_start");
        for (int k = 0; k < 4; k++) begin
            checkOutput("back_to_back_valid", 32'(txIf.tx_valid), 32'd1);
            @(negedge clk);
        end
        checkOutput("busy_after_frame", 32'(busy), 32'd0);
        waitDrain("first_frame");

        // Table of selection changes under various ready patterns.
        for (int v = 0; v < 7; v++) begin
            applyStimulus(vecs[v].img, vecs[v].res, vecs[v].out, vecs[v].letter, vecs[v].mode);
            waitDrain("vector");
        end

        // Input change while the letter byte is on the bus.
        applyStimulus(2'd3, 2'd2, 1'b1, 8'h77, 0);
        waitByte(8'h77, "mid_frame_letter");
        img = 2'd0;
        pushFrame(8'h79);
        waitDrain("mid_frame_change");

        // One request starts a frame, three more during it give one extra.
        rdyMode = 1;
        @(posedge clk);
        #1;
        statusReq = 1'b1;
        pushFrame(8'h79);
        @(posedge clk);
        #1;
        statusReq = 1'b0;
        waitByte(8'h23, "req_frame_start");
        repeat (3) begin
            @(posedge clk);
            #1;
            statusReq = 1'b1;
            @(posedge clk);
            #1;
            statusReq = 1'b0;
        end
        pushFrame(8'h79);
        waitDrain("status_req");
        validCount = 0;
        repeat (20) @(negedge clk);
        checkOutput("no_third_frame", 32'(validCount), 32'd0);

        // Reset while the CR byte is on the bus.
        applyStimulus(2'd2, 2'd0, 1'b0, 8'h69, 0);
        waitByte(8'h0D, "reach_idx2");
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(txIf.tx_valid), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_data", 32'(txIf.tx_data), 32'h00);
        expQ.delete();
        img    = 2'd0;
        res    = 2'd0;
        outSel = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        validCount = 0;
        repeat (20) @(negedge clk);
        checkOutput("no_frame_after_abort", 32'(validCount), 32'd0);

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
